// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if -- one requester's connection to the data-memory arbiter.
//
// Signals (master drives the request side, arbiter drives the response side):
//   req      request valid; held with its fields until gnt
//   addr     word address (ADDR_W bits)
//   byteena  byte enables for writes
//   wdata    write data
//   wren     1 = write, 0 = read
//   lock     keep ownership of the memory after this transfer
//   gnt      request accepted this cycle (combinational)
//   rvalid   read data valid, one cycle after an accepted read
//   rdata    read data, held while rvalid is low
interface dmem_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        byteena;
  logic [31:0]       wdata;
  logic              wren;
  logic              lock;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, addr, byteena, wdata, wren, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, byteena, wdata, wren, lock,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- shares the single-port data memory between the core
// load/store unit (m0) and the AES state/key fetch port (m1).
//
// Round-robin per cycle, optional burst lock bounded by MAX_HOLD cycles of
// the other master waiting, and registered read-data return (1-cycle latency).
//
// Ports:
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   m0, m1               requester interfaces (dmem_arbiter_if.slave)
//   mem_address/byteena/data/wren   to the memory, muxed from the granted master
//   mem_q                combinational read data from the memory
//   stat_gnt0/1, stat_conflict      saturating event counters
//
// Build option: define DMEM_ARB_STATS_EN to enable the counters; otherwise
// the stat outputs are present but tied to zero.
module dmem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int MAX_HOLD = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteena,
  output logic [31:0]       mem_data,
  output logic              mem_wren,
  input  logic [31:0]       mem_q,
  output logic [31:0]       stat_gnt0,
  output logic [31:0]       stat_gnt1,
  output logic [31:0]       stat_conflict
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state_reg, state_next;
  logic        last_gnt_reg, last_gnt_next;
  logic [7:0]  hold_cnt_reg, hold_cnt_next;
  logic [1:0]  gnt;
  logic [1:0]  rd_acc;
  logic        rvalid_reg [2];
  logic [31:0] rdata_reg  [2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      last_gnt_reg <= 1'b1;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      last_gnt_reg <= last_gnt_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    last_gnt_next = last_gnt_reg;
    hold_cnt_next = hold_cnt_reg;
    gnt           = 2'b00;
    case (state_reg)
      IDLE: begin
        hold_cnt_next = '0;
        // On a conflict the master that did not win last time goes first.
        if (m0.req && (!m1.req || last_gnt_reg))
          gnt[0] = 1'b1;
        else if (m1.req)
          gnt[1] = 1'b1;
        if (gnt[0]) begin
          last_gnt_next = 1'b0;
          if (m0.lock) state_next = OWN0;
        end
        if (gnt[1]) begin
          last_gnt_next = 1'b1;
          if (m1.lock) state_next = OWN1;
        end
      end
      OWN0: begin
        gnt[0] = m0.req;
        if (gnt[0]) begin
          last_gnt_next = 1'b0;
          if (!m0.lock) state_next = IDLE;
        end
        // Forced release overrides a lock request made in the same cycle;
        // last_gnt=0 hands the next conflict to m1.
        if (m1.req) begin
          if (hold_cnt_reg >= HOLD_LAST) begin
            state_next    = IDLE;
            last_gnt_next = 1'b0;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + 8'd1;
          end
        end else begin
          hold_cnt_next = '0;
        end
      end
      OWN1: begin
        gnt[1] = m1.req;
        if (gnt[1]) begin
          last_gnt_next = 1'b1;
          if (!m1.lock) state_next = IDLE;
        end
        if (m0.req) begin
          if (hold_cnt_reg >= HOLD_LAST) begin
            state_next    = IDLE;
            last_gnt_next = 1'b1;
            hold_cnt_next = '0;
          end else begin
            hold_cnt_next = hold_cnt_reg + 8'd1;
          end
        end else begin
          hold_cnt_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!reset_n) gnt = 2'b00;
  end

  // Memory-side mux; with no grant the memory sees m0's address/data but
  // no byte enables and no write.
  always_comb begin
    mem_address = m0.addr;
    mem_data    = m0.wdata;
    mem_byteena = 4'b0000;
    mem_wren    = 1'b0;
    if (gnt[0]) begin
      mem_byteena = m0.byteena;
      mem_wren    = m0.wren;
    end else if (gnt[1]) begin
      mem_address = m1.addr;
      mem_data    = m1.wdata;
      mem_byteena = m1.byteena;
      mem_wren    = m1.wren;
    end
  end

  assign rd_acc[0] = gnt[0] & ~m0.wren;
  assign rd_acc[1] = gnt[1] & ~m1.wren;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        rvalid_reg[i] <= 1'b0;
        rdata_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        rvalid_reg[i] <= rd_acc[i];
        if (rd_acc[i]) rdata_reg[i] <= mem_q;
      end
    end
  end

  assign m0.gnt    = gnt[0];
  assign m1.gnt    = gnt[1];
  assign m0.rvalid = rvalid_reg[0];
  assign m1.rvalid = rvalid_reg[1];
  assign m0.rdata  = rdata_reg[0];
  assign m1.rdata  = rdata_reg[1];

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_gnt0_reg, stat_gnt1_reg, stat_conflict_reg;
  logic        conflict;

  // Both requesting with at most one grant means someone was blocked.
  assign conflict = m0.req & m1.req & ~(gnt[0] & gnt[1]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_gnt0_reg     <= '0;
      stat_gnt1_reg     <= '0;
      stat_conflict_reg <= '0;
    end else begin
      if (gnt[0] && stat_gnt0_reg != 32'hFFFF_FFFF)
        stat_gnt0_reg <= stat_gnt0_reg + 32'd1;
      if (gnt[1] && stat_gnt1_reg != 32'hFFFF_FFFF)
        stat_gnt1_reg <= stat_gnt1_reg + 32'd1;
      if (conflict && stat_conflict_reg != 32'hFFFF_FFFF)
        stat_conflict_reg <= stat_conflict_reg + 32'd1;
    end
  end

  assign stat_gnt0     = stat_gnt0_reg;
  assign stat_gnt1     = stat_gnt1_reg;
  assign stat_conflict = stat_conflict_reg;
`else
  assign stat_gnt0     = '0;
  assign stat_gnt1     = '0;
  assign stat_conflict = '0;
`endif

endmodule
